// File: rtl/periph_pkg.sv
// Peripheral bus constants shared by clock_enable_gen and peripheral_controller.
// Covers the din field layout and the position of the SYNC register.
package periph_pkg;

   // SYNC register sits just past the last channel register.
   localparam int unsigned SYNC_OFS = 0;
   localparam int unsigned DIV_LSB  = 0;

   typedef enum logic [1:0] {
      ADDR_CHAN,
      ADDR_SYNC,
      ADDR_NONE
   } addr_kind_e;

   function automatic int unsigned en_bit(input int unsigned width);
      return width;
   endfunction

   function automatic int unsigned div_msb(input int unsigned width);
      return width - 1;
   endfunction

endpackage

// File: rtl/clock_enable_gen_if.sv
// Register bus and enable outputs of the clock-enable generator.
interface clock_enable_gen_if #(
   parameter int N_CH   = 4,
   parameter int WIDTH  = 24,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] address;
   logic [WIDTH:0]    din;
   logic              writeEnable;
   logic [WIDTH:0]    dout;
   logic [N_CH-1:0]   tick;
   logic [N_CH-1:0]   sq;

   modport master (output address, din, writeEnable, input dout, tick, sq);
   modport slave  (input address, din, writeEnable, output dout, tick, sq);
endinterface

// File: rtl/clock_enable_chan.sv
// One divider channel: counter, divisor/enable register, tick and square wave.
module clock_enable_chan
   import periph_pkg::*;
#(
   parameter int          WIDTH   = 24,
   parameter int unsigned DEF_DIV = 24999,
   parameter int unsigned DEF_EN  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic             sync,
   input  logic [WIDTH:0]   din,
   output logic [WIDTH-1:0] div,
   output logic             en,
   output logic             tick,
   output logic             sq
);
   localparam int unsigned EN_B  = en_bit(WIDTH);
   localparam int unsigned DIV_M = div_msb(WIDTH);

   logic [WIDTH-1:0] ctr;
   logic             tc;

   assign tc = (ctr == div);

   // A write or SYNC restarts the phase and swallows any terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div  <= WIDTH'(DEF_DIV);
         en   <= 1'(DEF_EN);
         ctr  <= '0;
         tick <= 1'b0;
         sq   <= 1'b0;
      end else if (wr) begin
         div  <= din[DIV_M:DIV_LSB];
         en   <= din[EN_B];
         ctr  <= '0;
         tick <= 1'b0;
         sq   <= 1'b0;
      end else if (sync || !en) begin
         ctr  <= '0;
         tick <= 1'b0;
         sq   <= 1'b0;
      end else begin
         ctr  <= tc ? '0 : ctr + WIDTH'(1);
         tick <= tc;
         if (tc) sq <= ~sq;
      end
   end

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: address decode,
// per-channel dividers and a registered readback mux.
module clock_enable_gen
   import periph_pkg::*;
#(
   parameter int          N_CH    = 4,
   parameter int          WIDTH   = 24,
   parameter int unsigned DEF_DIV = 24999,
   parameter int unsigned DEF_EN  = 1,
   parameter int          ADDR_W  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   clock_enable_gen_if.slave  bus
);
   logic [N_CH-1:0][WIDTH-1:0] div_v;
   logic [N_CH-1:0]            en_v;
   logic [N_CH-1:0]            tick_v;
   logic [N_CH-1:0]            sq_v;
   logic [N_CH-1:0]            wr_ch;
   logic                       sync_wr;
   logic [WIDTH:0]             rd_val;
   logic [WIDTH:0]             dout_q;
   addr_kind_e                 kind;

   always_comb begin
      kind = ADDR_NONE;
      if (bus.address < ADDR_W'(N_CH))
         kind = ADDR_CHAN;
      else if (bus.address == ADDR_W'(N_CH + SYNC_OFS))
         kind = ADDR_SYNC;
   end

   assign sync_wr = bus.writeEnable && (kind == ADDR_SYNC);

   // Only real channels contribute; SYNC and unmapped addresses read 0.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < N_CH; i++)
         if (bus.address == ADDR_W'(i)) rd_val = {en_v[i], div_v[i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= rd_val;
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign wr_ch[i] = bus.writeEnable && (kind == ADDR_CHAN) &&
                        (bus.address == ADDR_W'(i));

      clock_enable_chan #(
         .WIDTH   (WIDTH),
         .DEF_DIV (DEF_DIV),
         .DEF_EN  (DEF_EN)
      ) u_chan (
         .clk  (clk),
         .rst_n(rst_n),
         .wr   (wr_ch[i]),
         .sync (sync_wr),
         .din  (bus.din),
         .div  (div_v[i]),
         .en   (en_v[i]),
         .tick (tick_v[i]),
         .sq   (sq_v[i])
      );
   end

   assign bus.dout = dout_q;
   assign bus.tick = tick_v;
   assign bus.sq   = sq_v;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen; expectations come from a phase-origin
// model of each channel, queued per cycle and checked after the edge.
module tb_clock_enable_gen;
   localparam int N_CH = 4;
   localparam int W    = 16;
   localparam int AW   = 3;
   localparam int DEFD = 3;

   typedef struct {
      logic [N_CH-1:0] tick;
      logic [N_CH-1:0] sq;
      logic [W:0]      dout;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   clock_enable_gen_if #(.N_CH(N_CH), .WIDTH(W), .ADDR_W(AW)) bus ();

   clock_enable_gen #(
      .N_CH(N_CH), .WIDTH(W), .DEF_DIV(DEFD), .DEF_EN(1), .ADDR_W(AW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;
   int   ecnt = 0;
   int   div_m[N_CH];
   bit   en_m[N_CH];
   int   org[N_CH];

   function automatic logic [W:0] mk(input bit en, input int d);
      return {en, W'(d)};
   endfunction

   task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
      nvec++;
      assert (got === exp)
      else begin
         nerr++;
         $error("FAIL %s @edge %0d: got %0h expected %0h", tag, ecnt, got, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < N_CH; i++) begin
         div_m[i] = DEFD;
         en_m[i]  = 1'b1;
         org[i]   = ecnt;
      end
   endtask

   // One clock: derive expected post-edge outputs, then compare after the edge.
   task automatic cyc();
      exp_t e;
      exp_t g;
      int   a;
      bit   sy;
      e.tick = '0; e.sq = '0; e.dout = '0;
      if (rst_n) begin
         a  = int'(bus.address);
         sy = bus.writeEnable && (a == N_CH);
         if (a < N_CH) e.dout = mk(en_m[a], div_m[a]);
         for (int i = 0; i < N_CH; i++) begin
            if (bus.writeEnable && a == i) begin
               div_m[i] = int'(bus.din[W-1:0]);
               en_m[i]  = bus.din[W];
               org[i]   = ecnt + 1;
            end else if (sy) begin
               org[i] = ecnt + 1;
            end else if (en_m[i]) begin
               int k, p;
               k = ecnt + 1 - org[i];
               p = div_m[i] + 1;
               e.tick[i] = (k > 0) && (k % p == 0);
               e.sq[i]   = ((k / p) % 2) == 1;
            end
         end
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      ecnt++;
      g = q.pop_front();
      chk("tick", (W+1)'(bus.tick), (W+1)'(g.tick));
      chk("sq",   (W+1)'(bus.sq),   (W+1)'(g.sq));
      chk("dout", bus.dout, g.dout);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wr(input int a, input logic [W:0] d);
      bus.address = AW'(a);
      bus.din = d;
      bus.writeEnable = 1'b1;
      cyc();
      bus.writeEnable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      bus.address = '0;
      bus.din = '0;
      bus.writeEnable = 1'b0;
      reset_model();

      // reset held: everything 0
      run(2);
      #4 rst_n = 1'b1;
      reset_model();
      run(17);

      // ch1 div=0: tick stuck high, sq toggles
      wr(1, mk(1'b1, 0));
      run(6);

      // ch2 disable, then re-enable with div=9
      wr(2, mk(1'b0, 9));
      run(5);
      wr(2, mk(1'b1, 9));
      run(12);

      // write ch0 exactly on its terminal-count cycle
      bus.address = '0;
      for (int n = 0; n < 8; n++) begin
         if ((ecnt + 1 - org[0]) % (div_m[0] + 1) == 0) break;
         cyc();
      end
      wr(0, mk(1'b1, 5));
      run(14);

      // phase alignment through SYNC
      wr(0, mk(1'b1, 4));
      run(3);
      wr(3, mk(1'b1, 6));
      run(4);
      wr(N_CH, mk(1'b1, 1));
      bus.address = '0;
      run(36);
      bus.address = AW'(3);
      run(2);
      bus.address = AW'(N_CH);
      run(2);

      // unmapped address: no effect, reads 0
      wr(7, mk(1'b1, 0));
      run(3);

      // async reset between edges
      bus.address = AW'(1);
      run(2);
      #2 rst_n = 1'b0;
      reset_model();
      #1;
      chk("async_tick", (W+1)'(bus.tick), '0);
      chk("async_sq",   (W+1)'(bus.sq),   '0);
      chk("async_dout", bus.dout, '0);
      run(2);
      #4 rst_n = 1'b1;
      reset_model();
      bus.address = '0;
      run(10);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
